// File: rtl/mem_pkg.sv
// mem_pkg: shared types and width defaults for the memory arbiter.
//   arb_state_t - response ownership state (IDLE / OWN_I / OWN_D)
//   MEM_*       - default address/data widths and starvation limit
package mem_pkg;
    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} arb_state_t;
    localparam int MEM_ADDR_W     = 32;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_MAX_STARVE = 4;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of consecutive denied instruction requests.
//   clk, reset (async active-low)
//   req_i - instruction request pending, gnt_i - instruction request granted
//   sat_o - counter has reached MAX_STARVE
module arb_starve_cnt #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic sat_o
);
    localparam int CW = $clog2(MAX_STARVE + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        sat_o = cnt_q == CW'(MAX_STARVE);
        cnt_d = (req_i && !gnt_i) ? (sat_o ? cnt_q : cnt_q + 1'b1) : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction and a data port onto one single-port memory.
//   clk, reset (async active-low)
//   i_req/i_a/i_gnt, i_rvalid/i_rdata, i_kill - instruction fetch channel (read-only)
//   d_req/d_we/d_a/d_wd/d_wmask/d_gnt, d_rvalid/d_rdata - data channel
//   mem_en/mem_we/mem_a/mem_wd/mem_wmask/mem_rd - memory, 1-cycle read latency
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int MAX_STARVE = MEM_MAX_STARVE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_a,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                i_kill,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_a,
    input  logic [DATA_W-1:0]   d_wd,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_wd,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rd
);
    arb_state_t state_q, state_d;
    logic       starve_sat;

    arb_starve_cnt #(.MAX_STARVE(MAX_STARVE)) u_starve (
        .clk   (clk),
        .reset (reset),
        .req_i (i_req),
        .gnt_i (i_gnt),
        .sat_o (starve_sat)
    );

    // Grants are gated by reset so nothing reaches the memory while it is held.
    always_comb begin
        d_gnt     = reset & d_req & ~(i_req & starve_sat);
        i_gnt     = reset & i_req & ~d_gnt;
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_a     = i_gnt ? i_a : d_a;
        mem_wd    = d_wd;
        mem_wmask = mem_we ? d_wmask : '0;
        state_d   = i_gnt ? OWN_I : (d_gnt && !d_we) ? OWN_D : IDLE;
        i_rvalid  = (state_q == OWN_I) & ~i_kill;
        d_rvalid  = state_q == OWN_D;
    end

    assign i_rdata = mem_rd;
    assign d_rdata = mem_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
endmodule
